// File: rtl/iir_sos_cascade_if.sv
// Sample/result handshake and coefficient-bank port of the biquad cascade.
// The filter is the slave; the sample source / register master is the master.
interface iir_sos_cascade_if #(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 20,
  parameter int AW        = 5
);
  logic                        sample_trig;
  logic signed [DATA_SIZE-1:0] data_in;
  logic signed [DATA_SIZE-1:0] data_out;
  logic                        filter_end;
  logic                        busy;
  logic                        overrun;
  logic                        coef_we;
  logic [AW-1:0]               coef_addr;
  logic signed [COEF_SIZE-1:0] coef_wdata;
  logic                        coef_rej;

  modport master (
    output sample_trig, data_in, coef_we, coef_addr, coef_wdata,
    input  data_out, filter_end, busy, overrun, coef_rej
  );

  modport slave (
    input  sample_trig, data_in, coef_we, coef_addr, coef_wdata,
    output data_out, filter_end, busy, overrun, coef_rej
  );
endinterface

// File: rtl/iir_sos_cascade.sv
// Cascade of N_STAGES Direct Form I biquads sharing one multiplier-accumulator.
// Optional macro SOS_SATURATE_EN: clamp GAIN result and stage outputs instead of wrapping.
module iir_sos_cascade #(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 20,
  parameter int N_STAGES  = 4,
  parameter int ACC_SIZE  = DATA_SIZE + COEF_SIZE + 4,
  parameter int AW        = $clog2(N_STAGES) + 3
) (
  input logic clk,
  input logic reset,
  iir_sos_cascade_if.slave bus
);
  localparam int SW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int PW    = DATA_SIZE + COEF_SIZE;
  localparam int SHIFT = COEF_SIZE - 2;
  localparam logic signed [COEF_SIZE-1:0] ONE = COEF_SIZE'(1 << SHIFT);

  typedef enum logic [3:0] {
    S_IDLE, S_GAIN, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_STORE, S_DONE
  } state_t;

  state_t state, next_state;

  logic signed [COEF_SIZE-1:0] coef [N_STAGES][6];
  logic signed [DATA_SIZE-1:0] x1 [N_STAGES];
  logic signed [DATA_SIZE-1:0] x2 [N_STAGES];
  logic signed [DATA_SIZE-1:0] y1 [N_STAGES];
  logic signed [DATA_SIZE-1:0] y2 [N_STAGES];

  logic [SW-1:0]               stage;
  logic signed [DATA_SIZE-1:0] u_reg, x_reg, y_val, data_out_q;
  logic signed [ACC_SIZE-1:0]  acc, prod_ext;
  logic signed [DATA_SIZE-1:0] mul_a;
  logic signed [COEF_SIZE-1:0] mul_b;
  logic signed [PW-1:0]        prod;
  logic                        last_stage, overrun_q, coef_rej_q;
  logic [AW-4:0]               wr_stage;
  logic [2:0]                  wr_idx;
  logic [31:0]                 wr_stage_ext;
  logic                        wr_accept;

  // Rescale a Q2 product sum back to sample width, clamping or wrapping.
  function automatic logic signed [DATA_SIZE-1:0] scale_fit(input logic signed [ACC_SIZE-1:0] v);
`ifdef SOS_SATURATE_EN
    localparam logic signed [ACC_SIZE-1:0] SAT_HI = ACC_SIZE'((64'sd1 <<< (DATA_SIZE-1)) - 64'sd1);
    localparam logic signed [ACC_SIZE-1:0] SAT_LO = ~SAT_HI;
    logic signed [ACC_SIZE-1:0] s;
    s = v >>> SHIFT;
    if (s > SAT_HI)      return SAT_HI[DATA_SIZE-1:0];
    else if (s < SAT_LO) return SAT_LO[DATA_SIZE-1:0];
    else                 return s[DATA_SIZE-1:0];
`else
    return DATA_SIZE'(v >>> SHIFT);
`endif
  endfunction

  assign last_stage   = (32'(stage) == 32'(N_STAGES - 1));
  assign wr_stage     = bus.coef_addr[AW-1:3];
  assign wr_idx       = bus.coef_addr[2:0];
  assign wr_stage_ext = 32'(wr_stage);
  assign wr_accept    = bus.coef_we && (state == S_IDLE) && !bus.sample_trig &&
                        (wr_idx < 3'd6) && (wr_stage_ext < 32'(N_STAGES));

  assign bus.data_out   = data_out_q;
  assign bus.filter_end = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.coef_rej   = coef_rej_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.sample_trig) next_state = S_GAIN;
      S_GAIN:  next_state = S_MAC0;
      S_MAC0:  next_state = S_MAC1;
      S_MAC1:  next_state = S_MAC2;
      S_MAC2:  next_state = S_MAC3;
      S_MAC3:  next_state = S_MAC4;
      S_MAC4:  next_state = S_STORE;
      S_STORE: next_state = last_stage ? S_DONE : S_GAIN;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The single multiplier sees one (sample, coefficient) pair per cycle.
  always_comb begin
    mul_a = x_reg;
    mul_b = coef[stage][1];
    case (state)
      S_GAIN:  begin mul_a = u_reg;     mul_b = coef[stage][0]; end
      S_MAC1:  begin mul_a = x1[stage]; mul_b = coef[stage][2]; end
      S_MAC2:  begin mul_a = x2[stage]; mul_b = coef[stage][3]; end
      S_MAC3:  begin mul_a = y1[stage]; mul_b = coef[stage][4]; end
      S_MAC4:  begin mul_a = y2[stage]; mul_b = coef[stage][5]; end
      default: ;
    endcase
    prod     = mul_a * mul_b;
    prod_ext = {{(ACC_SIZE-PW){prod[PW-1]}}, prod};
    y_val    = scale_fit(acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage      <= '0;
      u_reg      <= '0;
      x_reg      <= '0;
      acc        <= '0;
      data_out_q <= '0;
      overrun_q  <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      if (bus.sample_trig && state != S_IDLE) overrun_q <= 1'b1;
      case (state)
        S_IDLE: if (bus.sample_trig) begin
          u_reg <= bus.data_in;
          stage <= '0;
        end
        S_GAIN:         x_reg <= scale_fit(prod_ext);
        S_MAC0:         acc   <= prod_ext;
        S_MAC1, S_MAC2: acc   <= acc + prod_ext;
        S_MAC3, S_MAC4: acc   <= acc - prod_ext;
        S_STORE: begin
          x2[stage] <= x1[stage];
          x1[stage] <= x_reg;
          y2[stage] <= y1[stage];
          y1[stage] <= y_val;
          u_reg     <= y_val;
          if (last_stage) data_out_q <= y_val;
          else            stage      <= stage + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coefficient bank comes out of reset as a pass-through (GAIN = B0 = 1.0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_rej_q <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        coef[s][0] <= ONE;
        coef[s][1] <= ONE;
        for (int i = 2; i < 6; i++) coef[s][i] <= '0;
      end
    end else begin
      coef_rej_q <= bus.coef_we && !wr_accept;
      if (wr_accept) coef[wr_stage][wr_idx] <= bus.coef_wdata;
    end
  end
endmodule
